// File: rtl/sprite_draw_scheduler_if.sv
// Sprite request bus from the movement controllers plus the pixel stream toward vga_adapter.
interface sprite_draw_scheduler_if #(
  parameter int NUM_SPRITES = 4
);
  logic                       tick;
  logic [NUM_SPRITES-1:0]     sprite_en;
  logic [8*NUM_SPRITES-1:0]   sprite_x;
  logic [7*NUM_SPRITES-1:0]   sprite_y;
  logic [25*NUM_SPRITES-1:0]  sprite_shape;
  logic [3*NUM_SPRITES-1:0]   sprite_colour;
  logic [7:0]                 x_out;
  logic [6:0]                 y_out;
  logic [2:0]                 col_out;
  logic                       plot;
  logic                       busy;
  logic                       done;
  logic                       tick_missed;

  modport master (
    output tick, sprite_en, sprite_x, sprite_y, sprite_shape, sprite_colour,
    input  x_out, y_out, col_out, plot, busy, done, tick_missed
  );

  modport slave (
    input  tick, sprite_en, sprite_x, sprite_y, sprite_shape, sprite_colour,
    output x_out, y_out, col_out, plot, busy, done, tick_missed
  );
endinterface

// File: rtl/sprite_draw_scheduler.sv
// Per-frame sequencer sharing one 5x5 pixel plotter between all sprites:
// erase each slot's old cell (when needed), then draw its new one, one pixel per clock.
module sprite_draw_scheduler #(
  parameter int         NUM_SPRITES  = 4,
  parameter logic [2:0] ERASE_COLOUR = 3'b000
) (
  input  logic                  clock,
  input  logic                  reset,
  sprite_draw_scheduler_if.slave bus
);
  localparam int SW  = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
  localparam int XW  = 8;
  localparam int YW  = 7;
  localparam int SHW = 25;
  localparam int CW  = 3;
  localparam logic [SW-1:0] LAST_SLOT = SW'(NUM_SPRITES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_SELECT, S_ERASE, S_DRAW, S_NEXT, S_FINISH
  } state_t;

  function automatic logic [7:0] pix_x(input logic [7:0] tile, input logic [2:0] off);
    return 8'(({3'b000, tile} * 11'd5) + {8'b0000_0000, off});
  endfunction

  function automatic logic [6:0] pix_y(input logic [6:0] tile, input logic [2:0] off);
    return 7'(({3'b000, tile} * 10'd5) + {7'b000_0000, off});
  endfunction

  // Bit 24 is row0/col0, row-major.
  function automatic logic shape_bit(input logic [24:0] shape, input logic [2:0] row,
                                     input logic [2:0] col);
    logic [4:0] idx;
    idx = 5'd24 - (({2'b00, row} * 5'd5) + {2'b00, col});
    return shape[idx];
  endfunction

  state_t                   state_q, state_d;
  logic [SW-1:0]            slot_q, slot_d;
  logic [2:0]               row_q, row_d;
  logic [2:0]               col_q, col_d;
  logic [NUM_SPRITES-1:0]   en_sh_q, en_sh_d;
  logic [XW*NUM_SPRITES-1:0]  x_sh_q, x_sh_d;
  logic [YW*NUM_SPRITES-1:0]  y_sh_q, y_sh_d;
  logic [SHW*NUM_SPRITES-1:0] shape_sh_q, shape_sh_d;
  logic [CW*NUM_SPRITES-1:0]  colour_sh_q, colour_sh_d;
  logic [XW*NUM_SPRITES-1:0]  prev_x_q, prev_x_d;
  logic [YW*NUM_SPRITES-1:0]  prev_y_q, prev_y_d;
  logic [NUM_SPRITES-1:0]   prev_valid_q, prev_valid_d;
  logic [7:0]               x_out_q, x_out_d;
  logic [6:0]               y_out_q, y_out_d;
  logic [2:0]               col_out_q, col_out_d;
  logic                     plot_q, plot_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     tick_missed_q, tick_missed_d;

  logic [XW-1:0]  cur_x_s, prv_x_s;
  logic [YW-1:0]  cur_y_s, prv_y_s;
  logic [SHW-1:0] cur_shape_s;
  logic [CW-1:0]  cur_colour_s;
  logic           cur_en_s, moved_s, last_pix_s;

  // Views of the slot currently being processed.
  always_comb begin
    cur_x_s      = x_sh_q[int'(slot_q)*XW +: XW];
    cur_y_s      = y_sh_q[int'(slot_q)*YW +: YW];
    cur_shape_s  = shape_sh_q[int'(slot_q)*SHW +: SHW];
    cur_colour_s = colour_sh_q[int'(slot_q)*CW +: CW];
    cur_en_s     = en_sh_q[slot_q];
    prv_x_s      = prev_x_q[int'(slot_q)*XW +: XW];
    prv_y_s      = prev_y_q[int'(slot_q)*YW +: YW];
    moved_s      = (cur_x_s != prv_x_s) || (cur_y_s != prv_y_s);
    last_pix_s   = (row_q == 3'd4) && (col_q == 3'd4);
  end

  // Next-state, counters, bookkeeping and registered pixel outputs.
  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    row_d         = row_q;
    col_d         = col_q;
    en_sh_d       = en_sh_q;
    x_sh_d        = x_sh_q;
    y_sh_d        = y_sh_q;
    shape_sh_d    = shape_sh_q;
    colour_sh_d   = colour_sh_q;
    prev_x_d      = prev_x_q;
    prev_y_d      = prev_y_q;
    prev_valid_d  = prev_valid_q;
    x_out_d       = x_out_q;
    y_out_d       = y_out_q;
    col_out_d     = col_out_q;
    plot_d        = 1'b0;
    busy_d        = busy_q;
    done_d        = 1'b0;
    tick_missed_d = bus.tick && (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (bus.tick) begin
          state_d = S_LATCH;
          busy_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LATCH: begin
        en_sh_d     = bus.sprite_en;
        x_sh_d      = bus.sprite_x;
        y_sh_d      = bus.sprite_y;
        shape_sh_d  = bus.sprite_shape;
        colour_sh_d = bus.sprite_colour;
        slot_d      = {SW{1'b0}};
        state_d     = S_SELECT;
      end
      S_SELECT: begin
        row_d = 3'd0;
        col_d = 3'd0;
        // An unmoved, still-enabled sprite is redrawn without an erase to avoid flicker.
        if (prev_valid_q[slot_q] && (!cur_en_s || moved_s)) begin
          state_d = S_ERASE;
        end else if (cur_en_s) begin
          state_d = S_DRAW;
        end else begin
          state_d = S_NEXT;
        end
      end
      S_ERASE, S_DRAW: begin
        plot_d = 1'b1;
        if (state_q == S_ERASE) begin
          x_out_d   = pix_x(prv_x_s, col_q);
          y_out_d   = pix_y(prv_y_s, row_q);
          col_out_d = ERASE_COLOUR;
        end else begin
          x_out_d   = pix_x(cur_x_s, col_q);
          y_out_d   = pix_y(cur_y_s, row_q);
          col_out_d = shape_bit(cur_shape_s, row_q, col_q) ? cur_colour_s : ERASE_COLOUR;
        end
        if (col_q == 3'd4) begin
          col_d = 3'd0;
          row_d = row_q + 3'd1;
        end else begin
          col_d = col_q + 3'd1;
        end
        if (last_pix_s) begin
          row_d = 3'd0;
          col_d = 3'd0;
          if (state_q == S_DRAW) begin
            prev_x_d[int'(slot_q)*XW +: XW] = cur_x_s;
            prev_y_d[int'(slot_q)*YW +: YW] = cur_y_s;
            prev_valid_d[slot_q]            = 1'b1;
            state_d                         = S_NEXT;
          end else if (cur_en_s) begin
            state_d = S_DRAW;
          end else begin
            prev_valid_d[slot_q] = 1'b0;
            state_d              = S_NEXT;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_NEXT: begin
        if (slot_q == LAST_SLOT) begin
          state_d = S_FINISH;
        end else begin
          slot_d  = slot_q + SW'(1);
          state_d = S_SELECT;
        end
      end
      S_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      slot_q        <= {SW{1'b0}};
      row_q         <= 3'd0;
      col_q         <= 3'd0;
      en_sh_q       <= {NUM_SPRITES{1'b0}};
      x_sh_q        <= {(XW*NUM_SPRITES){1'b0}};
      y_sh_q        <= {(YW*NUM_SPRITES){1'b0}};
      shape_sh_q    <= {(SHW*NUM_SPRITES){1'b0}};
      colour_sh_q   <= {(CW*NUM_SPRITES){1'b0}};
      prev_x_q      <= {(XW*NUM_SPRITES){1'b0}};
      prev_y_q      <= {(YW*NUM_SPRITES){1'b0}};
      prev_valid_q  <= {NUM_SPRITES{1'b0}};
      x_out_q       <= 8'd0;
      y_out_q       <= 7'd0;
      col_out_q     <= 3'd0;
      plot_q        <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      tick_missed_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      row_q         <= row_d;
      col_q         <= col_d;
      en_sh_q       <= en_sh_d;
      x_sh_q        <= x_sh_d;
      y_sh_q        <= y_sh_d;
      shape_sh_q    <= shape_sh_d;
      colour_sh_q   <= colour_sh_d;
      prev_x_q      <= prev_x_d;
      prev_y_q      <= prev_y_d;
      prev_valid_q  <= prev_valid_d;
      x_out_q       <= x_out_d;
      y_out_q       <= y_out_d;
      col_out_q     <= col_out_d;
      plot_q        <= plot_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      tick_missed_q <= tick_missed_d;
    end
  end

  assign bus.x_out       = x_out_q;
  assign bus.y_out       = y_out_q;
  assign bus.col_out     = col_out_q;
  assign bus.plot        = plot_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.tick_missed = tick_missed_q;
endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// Bench for sprite_draw_scheduler: table vectors, reset/abort sequences and random frames vs a frame-level model.
module tb_sprite_draw_scheduler;
  localparam int NS = 4;
  localparam logic [24:0] ALL = 25'h1FFFFFF;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  sprite_draw_scheduler_if #(.NUM_SPRITES(NS)) bus ();
  sprite_draw_scheduler #(.NUM_SPRITES(NS), .ERASE_COLOUR(3'b000)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  en;
    logic [31:0] x;
    logic [27:0] y;
    logic [99:0] shape;
    logic [11:0] colour;
    int          mid;
    int          n;
    int          ia;
    logic [17:0] pa;
    int          ib;
    logic [17:0] pb;
    int          contig;
  } vec_t;
  vec_t vecs[7];

  // model state: what the model believes is currently on screen per slot
  bit          m_valid[NS];
  logic [7:0]  m_px[NS];
  logic [6:0]  m_py[NS];
  logic [17:0] exp_q[$];
  logic [17:0] got_q[$];
  int exp_first, exp_last, exp_done;
  int fr_first, fr_last, fr_done, fr_missed, fr_busy_ok, fr_post_ok;

  function automatic logic [17:0] pk(input int x, input int y, input int c);
    return {x[7:0], y[6:0], c[2:0]};
  endfunction

  function automatic vec_t mk(input logic [3:0] en, input logic [31:0] x, input logic [27:0] y,
                              input logic [99:0] shape, input logic [11:0] colour, input int mid,
                              input int n, input int ia, input logic [17:0] pa, input int ib,
                              input logic [17:0] pb, input int contig);
    vec_t v;
    v.en = en; v.x = x; v.y = y; v.shape = shape; v.colour = colour; v.mid = mid;
    v.n = n; v.ia = ia; v.pa = pa; v.ib = ib; v.pb = pb; v.contig = contig;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic logic [17:0] model_pix(input logic [7:0] tx, input logic [6:0] ty,
                                            input int r, input int c, input logic [2:0] clr);
    int xi, yi;
    xi = (int'(tx) * 5 + c) % 256;
    yi = (int'(ty) * 5 + r) % 128;
    return {xi[7:0], yi[6:0], clr};
  endfunction

  // Expected pixel stream and timing of one frame, from the inputs present at tick time.
  task automatic model_frame();
    int t, p;
    exp_q.delete();
    t = 2; exp_first = -1; exp_last = -1;
    for (int s = 0; s < NS; s++) begin
      logic [7:0] nx; logic [6:0] ny; logic [24:0] shp; logic [2:0] clr; bit en;
      nx  = bus.sprite_x[8*s +: 8];
      ny  = bus.sprite_y[7*s +: 7];
      shp = bus.sprite_shape[25*s +: 25];
      clr = bus.sprite_colour[3*s +: 3];
      en  = bus.sprite_en[s];
      p = 0;
      if (m_valid[s] && (!en || nx != m_px[s] || ny != m_py[s])) begin
        for (int r = 0; r < 5; r++)
          for (int c = 0; c < 5; c++) exp_q.push_back(model_pix(m_px[s], m_py[s], r, c, 3'b000));
        m_valid[s] = 1'b0;
        p += 25;
      end
      if (en) begin
        for (int r = 0; r < 5; r++)
          for (int c = 0; c < 5; c++)
            exp_q.push_back(model_pix(nx, ny, r, c, shp[24 - (5*r + c)] ? clr : 3'b000));
        m_valid[s] = 1'b1; m_px[s] = nx; m_py[s] = ny;
        p += 25;
      end
      if (p > 0) begin
        if (exp_first < 0) exp_first = t + 1;
        exp_last = t + p;
      end
      t = t + p + 2;
    end
    exp_done = t;
  endtask

  task automatic randomize_inputs();
    logic [7:0] xpool[4];
    logic [6:0] ypool[4];
    xpool = '{8'd0, 8'd2, 8'd51, 8'd255};
    ypool = '{7'd0, 7'd1, 7'd25, 7'd127};
    bus.sprite_en = 4'($urandom);
    for (int s = 0; s < NS; s++) begin
      if ($urandom_range(0, 1) == 0) begin
        bus.sprite_x[8*s +: 8] = xpool[$urandom_range(0, 3)];
        bus.sprite_y[7*s +: 7] = ypool[$urandom_range(0, 3)];
      end
      bus.sprite_shape[25*s +: 25]  = 25'($urandom);
      bus.sprite_colour[3*s +: 3]   = 3'($urandom);
    end
  endtask

  // Pulse tick, then record plots, missed ticks and busy/done until done (bounded).
  task automatic run_frame(input int mid, input bit scramble);
    int idx;
    got_q.delete();
    fr_first = -1; fr_last = -1; fr_done = -1; fr_missed = 0; fr_busy_ok = 1; fr_post_ok = 1;
    bus.tick = 1'b1;
    idx = 0;
    while (fr_done < 0 && idx < 3000) begin
      @(negedge clock);
      if (bus.plot) begin
        got_q.push_back({bus.x_out, bus.y_out, bus.col_out});
        if (fr_first < 0) fr_first = idx;
        fr_last = idx;
      end
      if (bus.tick_missed) fr_missed++;
      if (bus.done) begin
        fr_done = idx;
        if (bus.busy) fr_busy_ok = 0;
      end else if (!bus.busy) begin
        fr_busy_ok = 0;
      end
      bus.tick = (idx == mid);
      if (scramble && idx == 2) randomize_inputs();
      idx++;
    end
    bus.tick = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      if (bus.plot || bus.done || bus.busy || bus.tick_missed) fr_post_ok = 0;
    end
  endtask

  task automatic check_frame(input string tag, input int mid);
    int bad, lim;
    chk({tag, " done_index"}, fr_done, exp_done);
    chk({tag, " busy_window"}, fr_busy_ok, 1);
    chk({tag, " idle_after_done"}, fr_post_ok, 1);
    chk({tag, " plot_count"}, got_q.size(), exp_q.size());
    lim = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    bad = -1;
    for (int i = 0; i < lim; i++) if (bad < 0 && got_q[i] != exp_q[i]) bad = i;
    if (bad < 0 && got_q.size() != exp_q.size()) bad = lim;
    chk({tag, " first_bad_pixel_index"}, bad, -1);
    if (exp_q.size() > 0) begin
      chk({tag, " first_plot_cycle"}, fr_first, exp_first);
      chk({tag, " last_plot_cycle"}, fr_last, exp_last);
    end
    chk({tag, " tick_missed_pulses"}, fr_missed, (mid >= 0 && mid < exp_done) ? 1 : 0);
  endtask

  initial begin
    int seen, mid;
    vecs[0] = mk(4'b0001, {8'd0, 8'd0, 8'd0, 8'd2}, {7'd0, 7'd0, 7'd0, 7'd3}, {ALL, ALL, ALL, ALL},
                 {3'd0, 3'd0, 3'd0, 3'd6}, 34, 25, 0, pk(10, 15, 6), 24, pk(14, 19, 6), 1);
    vecs[1] = mk(4'b0001, {8'd0, 8'd0, 8'd0, 8'd3}, {7'd0, 7'd0, 7'd0, 7'd3}, {ALL, ALL, ALL, ALL},
                 {3'd0, 3'd0, 3'd0, 3'd6}, -1, 50, 0, pk(10, 15, 0), 49, pk(19, 19, 6), 1);
    vecs[2] = mk(4'b0001, {8'd0, 8'd0, 8'd0, 8'd3}, {7'd0, 7'd0, 7'd0, 7'd3}, {ALL, ALL, ALL, ALL},
                 {3'd0, 3'd0, 3'd0, 3'd6}, 5, 25, 0, pk(15, 15, 6), 24, pk(19, 19, 6), 1);
    vecs[3] = mk(4'b0001, {8'd0, 8'd0, 8'd0, 8'd0}, {7'd0, 7'd0, 7'd0, 7'd0},
                 {ALL, ALL, ALL, 25'h1000000}, {3'd0, 3'd0, 3'd0, 3'd6}, -1, 50,
                 25, pk(0, 0, 6), 49, pk(4, 4, 0), 1);
    vecs[4] = mk(4'b1111, {8'd30, 8'd20, 8'd10, 8'd0}, {7'd6, 7'd4, 7'd2, 7'd0}, {ALL, ALL, ALL, ALL},
                 {3'd4, 3'd3, 3'd2, 3'd1}, 40, 100, 25, pk(50, 10, 2), 99, pk(154, 34, 4), 0);
    vecs[5] = mk(4'b0000, {8'd30, 8'd20, 8'd10, 8'd0}, {7'd6, 7'd4, 7'd2, 7'd0}, {ALL, ALL, ALL, ALL},
                 {3'd4, 3'd3, 3'd2, 3'd1}, -1, 100, 0, pk(0, 0, 0), 99, pk(154, 34, 0), 0);
    vecs[6] = mk(4'b0000, {8'd30, 8'd20, 8'd10, 8'd0}, {7'd6, 7'd4, 7'd2, 7'd0}, {ALL, ALL, ALL, ALL},
                 {3'd4, 3'd3, 3'd2, 3'd1}, -1, 0, -1, pk(0, 0, 0), -1, pk(0, 0, 0), -1);

    reset = 1'b1;
    bus.tick = 1'b0; bus.sprite_en = 4'd0; bus.sprite_x = 32'd0; bus.sprite_y = 28'd0;
    bus.sprite_shape = 100'd0; bus.sprite_colour = 12'd0;
    repeat (3) @(negedge clock);
    chk("reset x_out", int'(bus.x_out), 0);
    chk("reset y_out", int'(bus.y_out), 0);
    chk("reset col_out", int'(bus.col_out), 0);
    chk("reset plot", int'(bus.plot), 0);
    chk("reset busy", int'(bus.busy), 0);
    chk("reset done", int'(bus.done), 0);
    chk("reset tick_missed", int'(bus.tick_missed), 0);
    reset = 1'b0;
    for (int s = 0; s < NS; s++) m_valid[s] = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 7; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      bus.sprite_en = vecs[i].en; bus.sprite_x = vecs[i].x; bus.sprite_y = vecs[i].y;
      bus.sprite_shape = vecs[i].shape; bus.sprite_colour = vecs[i].colour;
      model_frame();
      run_frame(vecs[i].mid, 1'b0);
      check_frame(tag, vecs[i].mid);
      chk({tag, " table_plot_count"}, got_q.size(), vecs[i].n);
      if (vecs[i].ia >= 0)
        chk({tag, " table_pixel_a"}, (vecs[i].ia < got_q.size()) ? int'(got_q[vecs[i].ia]) : -1,
            int'(vecs[i].pa));
      if (vecs[i].ib >= 0)
        chk({tag, " table_pixel_b"}, (vecs[i].ib < got_q.size()) ? int'(got_q[vecs[i].ib]) : -1,
            int'(vecs[i].pb));
      if (vecs[i].contig >= 0)
        chk({tag, " table_contiguous"}, (fr_last - fr_first + 1 == got_q.size()) ? 1 : 0,
            vecs[i].contig);
    end

    // Reset in the middle of a draw pass, then redraw from a clean slate.
    bus.sprite_en = 4'b0001; bus.sprite_x = 32'd2; bus.sprite_y = 28'd3;
    bus.sprite_shape = {ALL, ALL, ALL, ALL}; bus.sprite_colour = 12'd6;
    bus.tick = 1'b1;
    @(negedge clock);
    bus.tick = 1'b0;
    seen = 0;
    for (int k = 0; k < 60 && seen < 5; k++) begin
      @(negedge clock);
      if (bus.plot) seen++;
    end
    chk("abort reached_draw", seen, 5);
    reset = 1'b1;
    @(negedge clock);
    chk("abort plot", int'(bus.plot), 0);
    chk("abort busy", int'(bus.busy), 0);
    chk("abort x_out", int'(bus.x_out), 0);
    reset = 1'b0;
    for (int s = 0; s < NS; s++) m_valid[s] = 1'b0;
    model_frame();
    run_frame(-1, 1'b0);
    check_frame("post_reset", -1);
    chk("post_reset draw_only_count", got_q.size(), 25);
    bus.sprite_en = 4'b0000;
    model_frame();
    run_frame(-1, 1'b0);
    check_frame("disable_slot0", -1);
    chk("disable_slot0 erase_count", got_q.size(), 25);

    for (int i = 0; i < 12; i++) begin
      randomize_inputs();
      mid = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 80)) : -1;
      model_frame();
      run_frame(mid, i[0]);
      check_frame($sformatf("rand%0d", i), mid);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sprite_draw_scheduler.md
Name: sprite_draw_scheduler

Overview:
Frame-level sequencer that shares the single 5x5 sprite pixel-plotting path between NUM_SPRITES movers (pacman plus ghosts).
- On each game tick it snapshots every sprite's tile position, shape and colour.
- For each slot in index order it erases the sprite's previously drawn cell, then draws the new one.
- It emits one pixel per clock toward vga_adapter (x, y, colour, plot).
- It sits between the rate divider / movement controllers and the VGA adapter, replacing per-sprite draw FSMs.

Parameters:
NUM_SPRITES, 4, number of requester slots; slot 0 has highest draw priority (drawn first).
ERASE_COLOUR, 3'b000, colour written on erase passes and for zero shape bits.

Ports:
clock  in  1  system clock (CLOCK_50 domain).
reset  in  1  synchronous, active-high reset.
tick  in  1  one-cycle frame-start pulse from the rate divider.
sprite_en  in  NUM_SPRITES  per-slot active flag.
sprite_x  in  8*NUM_SPRITES  tile x per slot; slot i at [8i+7:8i].
sprite_y  in  7*NUM_SPRITES  tile y per slot; slot i at [7i+6:7i].
sprite_shape  in  25*NUM_SPRITES  5x5 bitmap per slot; bit 24 is row0/col0, row-major.
sprite_colour  in  3*NUM_SPRITES  draw colour per slot.
x_out  out  8  pixel x.
y_out  out  7  pixel y.
col_out  out  3  pixel colour.
plot  out  1  pixel write enable.
busy  out  1  high from the cycle after an accepted tick until done.
done  out  1  one-cycle pulse when the frame sequence completes.
tick_missed  out  1  one-cycle pulse when tick arrives while busy.

Behaviour:
- Reset values: x_out=0, y_out=0, col_out=0, plot=0, busy=0, done=0, tick_missed=0. All prev_valid bits cleared. State=IDLE. Reset mid-frame aborts the frame: plot=0 from the next cycle. Pixels already written are not cleaned.
- State machine:
  - IDLE -> LATCH on tick.
  - LATCH: copy all sprite_* inputs into shadow registers (slot=0) -> SELECT.
  - SELECT for slot s:
    - If prev_valid[s] and (not en[s] or pos changed) -> ERASE.
    - Else if en[s] -> DRAW.
    - Else -> NEXT.
  - ERASE: 25 pixels at prev_pos[s] with ERASE_COLOUR. Then -> DRAW if en[s], else -> NEXT.
  - DRAW: 25 pixels at new pos. Update prev_pos[s], set prev_valid[s]=1. -> NEXT.
  - ERASE with en[s]=0 clears prev_valid[s].
  - NEXT: if s==NUM_SPRITES-1 -> FINISH, else s++ -> SELECT.
  - FINISH: done=1, busy=0 -> IDLE.
- Inputs are sampled only in LATCH. Changes during a frame have no effect until the next tick.
- Pixel counter: col 0..4 fastest, row 0..4. Resets to 0 at the start of each ERASE/DRAW pass. Wraps row 4/col 4 -> pass end.
- Pixel address: x_out = tile_x*5 + col, y_out = tile_y*5 + row, truncated to 8/7 bits (no clamping).
- Pixel colour in DRAW: shape[24 - (5*row + col)] ? colour : ERASE_COLOUR.
- Outputs are registered. A pass produces exactly 25 consecutive plot=1 cycles. plot=0 in IDLE, LATCH, SELECT, NEXT and FINISH.
- Timing: tick at edge T; the first plot=1 appears at T+3 when slot 0 is processed. One SELECT gap separates ERASE from the following DRAW only via the state change; no extra bubble is allowed between ERASE and DRAW of the same slot.
- Same position with prev_valid set: erase skipped, redraw only (prevents flicker).
- tick while busy: ignored, tick_missed pulses for one cycle, current frame unaffected. tick in the FINISH cycle is also missed.
- Frame with no enabled and no prev_valid slots: LATCH, NUM_SPRITES×(SELECT,NEXT), FINISH; done pulses, zero plots.

Test Plan:
1. Reset; en=0001, slot0 tile (2,3), shape all ones, colour 110; tick -> 25 plots with x 10..14, y 15..19, col 110; no erase; one done pulse; busy low afterwards.
2. After scenario 1, move slot0 to (3,3); tick -> 25 plots col 000 at x 10..14, then 25 plots col 110 at x 15..19, y 15..19; 50 plot cycles total.
3. Tick again with no move -> exactly 25 draw plots, no erase pass.
4. Shape 25'h1000000 at (0,0) -> pixel (0,0) col 110; the other 24 pixels col 000.
5. en=1111, four distinct positions; second tick pulsed mid-frame -> tick_missed one cycle; plots in slot order 0,1,2,3 with 100 draw cycles; exactly one done.
6. Clear en[0] after a draw -> tick gives 25 erase plots only. Next tick gives zero plots and a done pulse. Then assert reset mid-DRAW -> plot 0 next cycle; following tick draws with no erase.
